// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Groups the signals that pass between the pipeline datapath and the hazard
//   controller. The datapath side (master) presents the decoded ID fields, the
//   ID/EX register outputs and the branch resolution. The controller side
//   (slave) returns the stall/flush enables, the multi-cycle busy flag and the
//   stall statistic.
//
//   Signalling: there is no valid/ready pair here. Every signal is a level that
//   is valid for the whole cycle. pc_write/ifid_write low means "hold this
//   cycle". A flush high means "load a bubble at the next rising edge".
//
//   Parameter: STALL_CNT_W is the width of stall_count. It must match the
//   controller instance.
interface hazard_ctrl_if #(
  parameter int STALL_CNT_W = 32
);
  logic [4:0]             ifid_rs1;
  logic [4:0]             ifid_rs2;
  logic                   ifid_uses_rs2;
  logic                   ifid_is_mc;
  logic                   idex_memread;
  logic [4:0]             idex_rd;
  logic                   branch_taken;
  logic                   pc_write;
  logic                   ifid_write;
  logic                   ifid_flush;
  logic                   idex_flush;
  logic                   mc_busy;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_uses_rs2, ifid_is_mc,
           idex_memread, idex_rd, branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_flush, mc_busy, stall_count
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_uses_rs2, ifid_is_mc,
           idex_memread, idex_rd, branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_flush, mc_busy, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller that sits beside the ID stage. It covers three
//   cases:
//     - Load-use hazards: a load in EX whose rd is read by the ID instruction.
//     - Structural hazards on the shared multi-cycle (mul/div) unit.
//     - Taken-branch redirects.
//   It also tracks how long the multi-cycle unit stays occupied and keeps a
//   saturating count of stall cycles.
//
// Parameters
//   MC_LAT       cycles the multi-cycle unit stays occupied after an issue.
//                0 removes the occupancy tracking altogether.
//   STALL_CNT_W  width of the stall statistic.
//
// Ports
//   clk    pipeline clock, rising edge
//   reset  asynchronous, active-high
//   hz     hazard_ctrl_if.slave
//          inputs:  ifid_rs1/rs2, ifid_uses_rs2, ifid_is_mc, idex_memread,
//                   idex_rd, branch_taken
//          outputs: pc_write, ifid_write, ifid_flush, idex_flush, mc_busy,
//                   stall_count
module hazard_ctrl #(
  parameter int MC_LAT      = 4,
  parameter int STALL_CNT_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  localparam int CW = (MC_LAT > 0) ? $clog2(MC_LAT + 1) : 1;

  logic                   mc_nz;
  logic                   load_use;
  logic                   struct_haz;
  logic                   pc_write_c;
  logic                   ifid_write_c;
  logic                   ifid_flush_c;
  logic                   idex_flush_c;
  logic [STALL_CNT_W-1:0] stall_q;

  // x0 is hard-wired to zero, so a load into it never creates a dependency.
  assign load_use = hz.idex_memread && (hz.idex_rd != 5'd0) &&
                    ((hz.idex_rd == hz.ifid_rs1) ||
                     (hz.ifid_uses_rs2 && (hz.idex_rd == hz.ifid_rs2)));

  assign struct_haz = hz.ifid_is_mc && mc_nz;

  // Resolution order: reset, then branch redirect, then stall. A redirect
  // kills the ID instruction, so any hazard it carries no longer matters.
  always_comb begin
    pc_write_c   = 1'b1;
    ifid_write_c = 1'b1;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    if (reset) begin
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
    end else if (hz.branch_taken) begin
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
    end else if (load_use || struct_haz) begin
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      idex_flush_c = 1'b1;
    end
  end

  generate
    if (MC_LAT > 0) begin : g_mc
      logic [CW-1:0] mc_cnt;
      logic          issue;

      assign issue = hz.ifid_is_mc && !hz.branch_taken && !load_use && !struct_haz;

      // Loading MC_LAT on issue keeps mc_busy high for exactly MC_LAT cycles.
      // A held mc instruction then issues in the first cycle that sees zero.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          mc_cnt <= '0;
        end else if (issue) begin
          mc_cnt <= CW'(MC_LAT);
        end else if (mc_cnt != '0) begin
          mc_cnt <= mc_cnt - CW'(1);
        end
      end

      assign mc_nz = (mc_cnt != '0);
    end else begin : g_no_mc
      assign mc_nz = 1'b0;
    end
  endgenerate

  // Saturates at all-ones rather than wrapping back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!pc_write_c && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign hz.pc_write    = pc_write_c;
  assign hz.ifid_write  = ifid_write_c;
  assign hz.ifid_flush  = ifid_flush_c;
  assign hz.idex_flush  = idex_flush_c;
  assign hz.mc_busy     = mc_nz;
  assign hz.stall_count = stall_q;

endmodule
